// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style control FSM for a multicycle RV32I datapath.
// Sequence: FETCH -> EXEC -> (MEM) -> WB -> FETCH, with HALT as a reset-only sink.
// Optional build macro: MULTICYCLE_CTRL_ILLEGAL_HALT_EN. When it is defined, an
// unsupported opcode sets illegal_instr and halts. When it is undefined, the
// opcode retires as a NOP and illegal_instr is tied low.
// Handshake: mem_ack is a completion strobe. It is only sampled on the rising
// edge that ends a MEM cycle. Mem_read/Mem_write stay high in every MEM cycle
// until that edge sees mem_ack high.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        mem_ack,
  output logic        en_pc,
  output logic        RegWrite,
  output logic        AluSrc,
  output logic [3:0]  AluSel,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic [1:0]  sel_data_to_reg,
  output logic        illegal_instr,
  output logic        mem_timeout,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] SEL_MEM   = 2'd0;
  localparam logic [1:0] SEL_ALU   = 2'd1;
  localparam logic [1:0] SEL_PC4   = 2'd2;
  localparam logic [1:0] SEL_UPPER = 2'd3;

  localparam logic [31:0] IR_NOP   = 32'h0000_0013;
  localparam logic [8:0]  WAIT_MAX = 9'(MEM_WAIT_MAX);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_nxt;
  logic [8:0]  wait_cnt_inc;
  logic        timeout_q;
  logic        timeout_set;

  // Decoded view of IR; it stays constant from EXEC through WB.
  logic        dec_legal;
  logic        dec_load;
  logic        dec_store;
  logic        dec_writes;
  logic        dec_alu_src;
  logic [3:0]  dec_alu_sel;
  logic [1:0]  dec_sel;

  // IR fields that the control path never looks at.
  logic        ir_unused;
  assign ir_unused = ^{ir[31], ir[29:15]};

  assign state_dbg    = state;
  assign mem_timeout  = timeout_q;
  assign wait_cnt_inc = {1'b0, wait_cnt} + 9'd1;

  // Maps funct3 to an ALU operation. alt selects SUB/SRA over ADD/SRL.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Instruction decode from the latched IR only.
  always_comb begin
    dec_legal   = 1'b1;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_writes  = 1'b0;
    dec_alu_src = 1'b0;
    dec_alu_sel = ALU_ADD;
    dec_sel     = SEL_ALU;
    case (ir[6:0])
      OPC_OP: begin
        dec_writes  = 1'b1;
        dec_alu_src = 1'b1;
        dec_alu_sel = alu_from_funct(ir[14:12], ir[30]);
      end
      OPC_OPIMM: begin
        // funct7[5] only matters for the shift-right-immediate pair.
        dec_writes  = 1'b1;
        dec_alu_sel = alu_from_funct(ir[14:12], (ir[14:12] == 3'b101) && ir[30]);
      end
      OPC_LOAD: begin
        dec_load   = 1'b1;
        dec_writes = 1'b1;
        dec_sel    = SEL_MEM;
      end
      OPC_STORE: begin
        dec_store = 1'b1;
      end
      OPC_BRANCH: begin
        dec_alu_src = 1'b1;
        dec_alu_sel = ALU_SUB;
      end
      OPC_JAL, OPC_JALR: begin
        dec_writes = 1'b1;
        dec_sel    = SEL_PC4;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_writes = 1'b1;
        dec_sel    = SEL_UPPER;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_HALT_EN
  logic illegal_q;
  logic illegal_set;
  assign illegal_instr = illegal_q;

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end
  end
`else
  assign illegal_instr = 1'b0;
`endif

  // Next-state, wait-counter and sticky-flag set logic.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_HALT_EN
    illegal_set  = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        wait_cnt_nxt = '0;
        if (dec_load || dec_store) begin
          state_nxt = S_MEM;
`ifdef MULTICYCLE_CTRL_ILLEGAL_HALT_EN
        end else if (!dec_legal) begin
          state_nxt   = S_HALT;
          illegal_set = 1'b1;
`endif
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        // An ack on the last allowed cycle still completes the access.
        if (mem_ack) begin
          state_nxt = S_WB;
        end else if (wait_cnt_inc == WAIT_MAX) begin
          state_nxt   = S_HALT;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt_inc[7:0];
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // State register, IR capture in FETCH, wait counter and timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      ir        <= IR_NOP;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == S_FETCH) begin
        ir <= instruction;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Moore outputs. Decoded controls are held from EXEC to WB, and the
  // enables are qualified by state. While reset_n is low, every output is
  // forced to 0 without waiting for a clock, so a MEM access is dropped at once.
  always_comb begin
    en_pc           = 1'b0;
    RegWrite        = 1'b0;
    AluSrc          = 1'b0;
    AluSel          = ALU_ADD;
    Mem_read        = 1'b0;
    Mem_write       = 1'b0;
    sel_data_to_reg = SEL_ALU;
    case (state)
      S_EXEC: begin
        AluSrc          = dec_alu_src;
        AluSel          = dec_alu_sel;
        sel_data_to_reg = dec_sel;
      end
      S_MEM: begin
        AluSrc          = dec_alu_src;
        AluSel          = dec_alu_sel;
        sel_data_to_reg = dec_sel;
        Mem_read        = dec_load;
        Mem_write       = dec_store;
      end
      S_WB: begin
        AluSrc          = dec_alu_src;
        AluSel          = dec_alu_sel;
        sel_data_to_reg = dec_sel;
        en_pc           = 1'b1;
        RegWrite        = dec_writes && (ir[11:7] != 5'd0);
      end
      default: begin
        en_pc = 1'b0;
      end
    endcase
    if (!reset_n) begin
      en_pc           = 1'b0;
      RegWrite        = 1'b0;
      AluSrc          = 1'b0;
      AluSel          = 4'd0;
      Mem_read        = 1'b0;
      Mem_write       = 1'b0;
      sel_data_to_reg = 2'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of multicycle_ctrl against a per-cycle
// behavioural model. The model expands each instruction into its expected
// cycle sequence from the block's rules.
module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int W        = 13;

`ifdef MULTICYCLE_CTRL_ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        mem_ack = 1'b0;
  logic        en_pc, RegWrite, AluSrc, Mem_read, Mem_write;
  logic        illegal_instr, mem_timeout;
  logic [3:0]  AluSel;
  logic [1:0]  sel_data_to_reg;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .instruction(instruction),
    .mem_ack(mem_ack),
    .en_pc(en_pc),
    .RegWrite(RegWrite),
    .AluSrc(AluSrc),
    .AluSel(AluSel),
    .Mem_read(Mem_read),
    .Mem_write(Mem_write),
    .sel_data_to_reg(sel_data_to_reg),
    .illegal_instr(illegal_instr),
    .mem_timeout(mem_timeout),
    .state_dbg(state_dbg)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {en_pc, RegWrite, AluSrc, AluSel, Mem_read, Mem_write,
                    sel_data_to_reg, illegal_instr, mem_timeout};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           model_illegal = 1'b0;
  bit           model_timeout = 1'b0;

  logic [W-1:0] cmp_exp;
  string        cmp_tag;

  // One expected vector is popped and compared in each cycle that has one.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_exp = exp_q.pop_front();
      cmp_tag = tag_q.pop_front();
      checks++;
      if (dut_vec !== cmp_exp) begin
        errors++;
        $display("FAIL %s: got %b required %b (en,rw,src,sel4,rd,wr,sel2,ill,to)",
                 cmp_tag, dut_vec, cmp_exp);
      end
    end
  end

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic       legal;
    logic       load;
    logic       store;
    logic       writes;
    logic       src;
    logic [3:0] asel;
    logic [1:0] sel;
  } dec_t;

  function automatic dec_t model_decode(logic [31:0] w);
    dec_t  d;
    string cls;
    int    base[8];
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    case (w[6:0])
      7'h33:   cls = "OP";
      7'h13:   cls = "OPIMM";
      7'h03:   cls = "LOAD";
      7'h23:   cls = "STORE";
      7'h63:   cls = "BRANCH";
      7'h6F:   cls = "JAL";
      7'h67:   cls = "JALR";
      7'h37:   cls = "LUI";
      7'h17:   cls = "AUIPC";
      default: cls = "BAD";
    endcase
    d        = '0;
    d.legal  = (cls != "BAD");
    d.load   = (cls == "LOAD");
    d.store  = (cls == "STORE");
    d.writes = (cls == "OP") || (cls == "OPIMM") || (cls == "LOAD") || (cls == "JAL") ||
               (cls == "JALR") || (cls == "LUI") || (cls == "AUIPC");
    d.src    = (cls == "OP") || (cls == "BRANCH");
    d.sel    = (cls == "LOAD") ? 2'd0 :
               (cls == "JAL" || cls == "JALR") ? 2'd2 :
               (cls == "LUI" || cls == "AUIPC") ? 2'd3 : 2'd1;
    if (cls == "OP")
      d.asel = 4'(base[w[14:12]] + ((w[30] && (w[14:12] == 3'd0 || w[14:12] == 3'd5)) ? 1 : 0));
    else if (cls == "OPIMM")
      d.asel = 4'(base[w[14:12]] + ((w[30] && w[14:12] == 3'd5) ? 1 : 0));
    else if (cls == "BRANCH")
      d.asel = 4'd1;
    else
      d.asel = 4'd0;
    return d;
  endfunction

  function automatic logic [W-1:0] pack(bit en, bit rw, bit src, logic [3:0] asel,
                                        bit mr, bit mw, logic [1:0] sel);
    return {en, rw, src, asel, mr, mw, sel, model_illegal, model_timeout};
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return pack(0, 0, 0, 4'd0, 0, 0, 2'd1);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drive one cycle of inputs and its expectation.
  task automatic cycle_push(logic [31:0] w, bit ack, logic [W-1:0] e, string t);
    instruction = w;
    mem_ack     = ack;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic halt_cycles(string name, int n);
    for (int i = 0; i < n; i++)
      cycle_push($urandom(), 1'($urandom_range(0, 1)), idle_vec(), {name, "_halt"});
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    model_illegal = 1'b0;
    model_timeout = 1'b0;
    for (int i = 0; i < 2; i++)
      cycle_push($urandom(), 1'($urandom_range(0, 1)), '0, "reset");
    reset_n = 1'b1;
  endtask

  // Expands one instruction into expected cycles. The instruction input is
  // only valid in FETCH; afterwards it carries junk.
  task automatic run_instr(string name, logic [31:0] w, int waits, bit never_ack,
                           output int cycles);
    dec_t d;
    bit   ack;
    d      = model_decode(w);
    cycles = 0;
    cycle_push(w, 1'($urandom_range(0, 1)), idle_vec(), {name, "_fetch"});
    cycles++;
    cycle_push($urandom(), 1'($urandom_range(0, 1)),
               pack(0, 0, d.src, d.asel, 0, 0, d.sel), {name, "_exec"});
    cycles++;
    if (!d.legal && HALT_EN) begin
      model_illegal = 1'b1;
      halt_cycles(name, 3);
      return;
    end
    if (d.load || d.store) begin
      for (int k = 0; k < WAIT_MAX; k++) begin
        ack = !never_ack && (k == waits);
        cycle_push($urandom(), ack, pack(0, 0, d.src, d.asel, d.load, d.store, d.sel),
                   {name, "_mem"});
        cycles++;
        if (ack) break;
        if (k + 1 == WAIT_MAX) begin
          model_timeout = 1'b1;
          halt_cycles(name, 3);
          return;
        end
      end
    end
    cycle_push($urandom(), 1'($urandom_range(0, 1)),
               pack(1, d.writes && (w[11:7] != 5'd0), d.src, d.asel, 0, 0, d.sel),
               {name, "_wb"});
    cycles++;
  endtask

  // Directed vector: hand-computed decode and latency pin the model first.
  task automatic do_vec(string name, logic [31:0] w, int waits,
                        int e_asel, int e_sel, int e_src, int e_rw, int e_cyc);
    dec_t d;
    int   cyc;
    d = model_decode(w);
    check({name, "_alusel"}, int'(d.asel), e_asel);
    check({name, "_sel"},    int'(d.sel),  e_sel);
    check({name, "_alusrc"}, int'(d.src),  e_src);
    check({name, "_regwr"},  int'(d.writes && (w[11:7] != 5'd0)), e_rw);
    run_instr(name, w, waits, 1'b0, cyc);
    check({name, "_cycles"}, cyc, e_cyc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   cyc;
    dec_t d;
    @(posedge clk);
    #1;
    do_reset();

    //      name     word          waits asel sel src rw cycles
    do_vec("add",    32'h002081B3, 0,    0,   1,  1,  1, 3);
    do_vec("lw_w2",  32'h0080A283, 2,    0,   0,  0,  1, 6);
    do_vec("sub_x0", 32'h40208033, 0,    1,   1,  1,  0, 3);
    do_vec("beq",    32'h00208463, 0,    1,   1,  1,  0, 3);
    do_vec("srai",   32'h4033D313, 0,    7,   1,  0,  1, 3);
    do_vec("addi",   32'h40000093, 0,    0,   1,  0,  1, 3);
    do_vec("sra",    32'h4062D233, 0,    7,   1,  1,  1, 3);
    do_vec("and",    32'h00A4F433, 0,    9,   1,  1,  1, 3);
    do_vec("sltu",   32'h003130B3, 0,    4,   1,  1,  1, 3);
    do_vec("slli",   32'h00109093, 0,    2,   1,  0,  1, 3);
    do_vec("jal",    32'h000000EF, 0,    0,   2,  0,  1, 3);
    do_vec("jalr_x0",32'h00008067, 0,    0,   2,  0,  0, 3);
    do_vec("lui",    32'h123452B7, 0,    0,   3,  0,  1, 3);
    do_vec("auipc",  32'h00001317, 0,    0,   3,  0,  1, 3);
    do_vec("sw_last",32'h00A20000 | 32'h0000A223 & 32'h00FFFFFF, 3, 0, 1, 0, 0, 7);
    do_vec("lw_w0",  32'h0080A283, 0,    0,   0,  0,  1, 4);

    // Unsupported opcode 0x7F.
    d = model_decode(32'h0000007F);
    check("illegal_model_legal", int'(d.legal), 0);
    run_instr("illegal", 32'h0000007F, 0, 1'b0, cyc);
`ifdef MULTICYCLE_CTRL_ILLEGAL_HALT_EN
    check("illegal_cycles", cyc, 2);
    check("illegal_flag", int'(illegal_instr), 1);
`else
    check("illegal_cycles", cyc, 3);
    check("illegal_flag", int'(illegal_instr), 0);
`endif
    do_reset();

    // Reset in the middle of a store's MEM phase.
    cycle_push(32'h0020A223, 1'b0, idle_vec(), "rst_sw_fetch");
    cycle_push($urandom(), 1'b0, pack(0, 0, 0, 4'd0, 0, 0, 2'd1), "rst_sw_exec");
    instruction = $urandom();
    mem_ack     = 1'b0;
    exp_q.push_back(pack(0, 0, 0, 4'd0, 0, 1, 2'd1));
    tag_q.push_back("rst_sw_mem");
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem_write", int'(Mem_write), 0);
    check("rst_mid_mem_outputs", int'(dut_vec), 0);
    @(posedge clk);
    #1;
    do_reset();
    check("rst_flags_clear", int'({illegal_instr, mem_timeout}), 0);
    do_vec("add_after_rst", 32'h002081B3, 0, 0, 1, 1, 1, 3);

    // Store that never sees mem_ack: timeout after WAIT_MAX MEM cycles.
    run_instr("sw_timeout", 32'h0020A223, 0, 1'b1, cyc);
    check("sw_timeout_cycles", cyc, 2 + WAIT_MAX);
    check("sw_timeout_flag", int'(mem_timeout), 1);
    halt_cycles("sw_timeout_more", 2);

    // Only reset leaves HALT.
    do_reset();
    do_vec("nop_after_halt", 32'h00000013, 0, 0, 1, 0, 0, 3);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
